alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready handshake on both sides.
// Single-cycle ops complete one cycle after accept.
// The shift-add multiplier (opcode 1100) is compiled only when ALU_MC_MUL_EN
// is defined. Without the macro, 1100 decodes as an illegal opcode.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       ALUControl,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Z,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SW = $clog2(WIDTH);

    // FSM encoding kept as plain constants for compatibility with older tooling
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
`ifdef ALU_MC_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1100;
`endif

    // Even bits set, odd bits clear: nonzero, so Z is always 0 for it
    localparam logic [WIDTH-1:0] ILLEGAL = {(WIDTH/2){2'b01}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic             accept;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;

    // Multiplier hooks; tied off when the multiplier is not built
    logic             go_busy;
    logic             mul_last;
    logic [WIDTH-1:0] acc_next;

    // Handshake outputs are pure state decodes
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        accept    = in_valid && (state == IDLE);
        shamt     = b_in[SW-1:0];
    end

    // Single-cycle datapath; unlisted opcodes (incl. mul when not built) are illegal
    always_comb begin
        alu_res = ILLEGAL;
        case (ALUControl)
            OP_ADD:  alu_res = a_in + b_in;
            OP_SUB:  alu_res = a_in + ~b_in + ONE;
            OP_AND:  alu_res = a_in & b_in;
            OP_XOR:  alu_res = a_in ^ b_in;
            OP_OR:   alu_res = a_in | b_in;
            OP_SLT:  alu_res = ($signed(a_in) < $signed(b_in)) ? ONE : '0;
            OP_SLTU: alu_res = (a_in < b_in) ? ONE : '0;
            OP_SLL:  alu_res = a_in << shamt;
            OP_SRL:  alu_res = a_in >> shamt;
            OP_SRA:  alu_res = $signed(a_in) >>> shamt;
            default: alu_res = ILLEGAL;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);
    localparam logic [SW-1:0] CNT_ONE  = {{(SW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SW-1:0]    cnt;

    // Next accumulator value and completion decode for the shift-add loop
    always_comb begin
        go_busy  = accept && (ALUControl == OP_MUL);
        mul_last = (state == BUSY) && (cnt == CNT_LAST);
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    // Shift-add: one multiplier bit per BUSY cycle, low WIDTH bits retained
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (go_busy) begin
            mcand  <= a_in;
            mplier <= b_in;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_ONE;
        end
    end
`else
    // Multiplier absent: BUSY is unreachable
    always_comb begin
        go_busy  = 1'b0;
        mul_last = 1'b0;
        acc_next = '0;
    end
`endif

    // Control FSM and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ALUResult <= '0;
            Z         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go_busy) begin
                        state <= BUSY;
                    end else if (accept) begin
                        state     <= DONE;
                        ALUResult <= alu_res;
                        Z         <= (alu_res == '0);
                    end
                end
                BUSY: begin
                    if (mul_last) begin
                        state     <= DONE;
                        ALUResult <= acc_next;
                        Z         <= (acc_next == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
